mult_div_hilo: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core, fed from E stage.
- Supersedes the purely combinational HI/LO select: adds operand latching, configurable latency, a busy/stall handshake, multiply-accumulate, and direct HI/LO writes.
- The stall unit uses `busy` to hold any dependent mult/div/mfhi/mflo in D.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mult_div_hilo_if.sv | 27 ++
 rtl/md_arith.sv | 72 +++++++
 rtl/mult_div_hilo.sv | 108 ++++++++++
 tb/tb_mult_div_hilo.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and sizing helpers.
package mdu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101,
    MD_MADD  = 3'b110,
    MD_MADDU = 3'b111
  } md_op_e;

  // Bits needed to hold the larger of the two busy-cycle counts.
  function automatic int unsigned cnt_width(input int unsigned mult_cycles,
                                            input int unsigned div_cycles);
    int unsigned m;
    m = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mult_div_hilo_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
interface mult_div_hilo_if #(
  parameter int unsigned WIDTH = 32
);
  import mdu_pkg::*;

  logic             start;
  md_op_e           op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             hilo_sel;
  logic             busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic [WIDTH-1:0] hilo_out;

  modport master (
    output start, op, A, B, hilo_sel,
    input  busy, HI, LO, hilo_out
  );

  modport slave (
    input  start, op, A, B, hilo_sel,
    output busy, HI, LO, hilo_out
  );

endinterface

// File: rtl/md_arith.sv
// Combinational datapath: {HI,LO} result for every mult/div op plus a divide-by-zero flag.
module md_arith
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  md_op_e             op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] hilo,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int unsigned DW = 2 * WIDTH;

  logic signed [DW-1:0] sa;
  logic signed [DW-1:0] sb;
  logic        [DW-1:0] ua;
  logic        [DW-1:0] ub;
  logic        [DW-1:0] prod_s;
  logic        [DW-1:0] prod_u;

  assign sa     = {{WIDTH{a[WIDTH-1]}}, a};
  assign sb     = {{WIDTH{b[WIDTH-1]}}, b};
  assign ua     = {{WIDTH{1'b0}}, a};
  assign ub     = {{WIDTH{1'b0}}, b};
  assign prod_s = sa * sb;
  assign prod_u = ua * ub;

  // Signed divide via magnitudes so the -2^(W-1)/-1 case wraps to itself with a zero remainder.
  logic [WIDTH-1:0] b_nz;
  logic [WIDTH-1:0] q_u;
  logic [WIDTH-1:0] r_u;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] r_s;

  assign b_nz  = (b == '0) ? WIDTH'(1) : b;
  assign q_u   = a / b_nz;
  assign r_u   = a % b_nz;
  assign abs_a = a[WIDTH-1] ? (WIDTH'(0) - a) : a;
  assign abs_b = b_nz[WIDTH-1] ? (WIDTH'(0) - b_nz) : b_nz;
  assign q_mag = abs_a / abs_b;
  assign r_mag = abs_a % abs_b;
  assign q_s   = (a[WIDTH-1] ^ b[WIDTH-1]) ? (WIDTH'(0) - q_mag) : q_mag;
  assign r_s   = a[WIDTH-1] ? (WIDTH'(0) - r_mag) : r_mag;

  always_comb begin
    result      = hilo;
    div_by_zero = 1'b0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_MADD:  result = hilo + prod_s;
      MD_MADDU: result = hilo + prod_u;
      MD_DIV: begin
        result      = {r_s, q_s};
        div_by_zero = (b == '0);
      end
      MD_DIVU: begin
        result      = {r_u, q_u};
        div_by_zero = (b == '0);
      end
      default:  result = hilo;
    endcase
  end

endmodule

// File: rtl/mult_div_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO and a busy handshake for the stall unit.
module mult_div_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic              clk,
  input logic              reset,
  mult_div_hilo_if.slave   md
);

  localparam int unsigned CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   pend_q, pend_d;
  logic                 pend_wr_q, pend_wr_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic [2*WIDTH-1:0]   arith_result;
  logic                 arith_div0;
  logic                 op_is_div;

  md_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .op          (md.op),
    .a           (md.A),
    .b           (md.B),
    .hilo        ({hi_q, lo_q}),
    .result      (arith_result),
    .div_by_zero (arith_div0)
  );

  assign op_is_div = (md.op == MD_DIV) || (md.op == MD_DIVU);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Result is computed at issue and parked; HI/LO only move on the completion edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (md.start) begin
          case (md.op)
            MD_MTHI: hi_d = md.A;
            MD_MTLO: lo_d = md.A;
            default: begin
              pend_d    = arith_result;
              pend_wr_d = ~arith_div0;
              cnt_d     = op_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              state_d   = S_RUN;
            end
          endcase
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          pend_wr_d = 1'b0;
          if (pend_wr_q) begin
            hi_d = pend_q[2*WIDTH-1:WIDTH];
            lo_d = pend_q[WIDTH-1:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign md.busy     = (state_q == S_RUN);
  assign md.HI       = hi_q;
  assign md.LO       = lo_q;
  assign md.hilo_out = md.hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_hilo.sv
// Scoreboard bench for mult_div_hilo: issue side queues expected HI/LO, monitor checks on busy fall.
module tb_mult_div_hilo;
  import mdu_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mult_div_hilo_if #(.WIDTH(W)) md ();

  mult_div_hilo #(
    .WIDTH       (W),
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         sb_q[$];
  int           n_pass  = 0;
  int           n_total = 0;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;
  bit           prev_busy = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every falling edge of busy is a completion and must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (prev_busy && (md.busy === 1'b0)) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_underflow: completion seen with HI=0x%08h LO=0x%08h, none expected",
                 md.HI, md.LO);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_HI"}, md.HI, e.hi);
        check({e.name, "_LO"}, md.LO, e.lo);
      end
    end
    prev_busy = (md.busy === 1'b1);
  end

  // Issue one arithmetic op at a negedge; optionally poke MTLO (kind 1) or reset (kind 2) mid-flight.
  task automatic do_op(input string name, input md_op_e op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el,
                       input int n, input int poke_cyc, input int poke_kind);
    int cnt;
    cnt = 0;
    sb_q.push_back('{name, eh, el});
    md.start = 1'b1;
    md.op    = op;
    md.A     = a;
    md.B     = b;
    @(negedge clk);
    md.start = 1'b0;
    while ((md.busy === 1'b1) && (cnt < 200)) begin
      if (cnt == 0) check({name, "_hold_lo"}, md.hilo_out, m_lo);
      if (poke_kind != 0 && cnt == poke_cyc) begin
        if (poke_kind == 1) begin
          md.start = 1'b1;
          md.op    = MD_MTLO;
          md.A     = 32'h0000_DEAD;
        end else begin
          reset = 1'b1;
        end
      end
      if (poke_kind == 1 && cnt == poke_cyc + 1) md.start = 1'b0;
      cnt++;
      @(negedge clk);
    end
    reset    = 1'b0;
    md.start = 1'b0;
    check({name, "_busy_cycles"}, W'(cnt), W'(n));
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    reset       = 1'b1;
    md.start    = 1'b0;
    md.op       = MD_MULT;
    md.A        = '0;
    md.B        = '0;
    md.hilo_sel = 1'b0;
    m_hi        = '0;
    m_lo        = '0;
    repeat (2) @(negedge clk);
    check("reset_HI", md.HI, 32'h0);
    check("reset_LO", md.LO, 32'h0);
    check("reset_busy", W'(md.busy), 32'h0);
    check("reset_hilo_out", md.hilo_out, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    do_op("mult",  MD_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5, 0, 0);
    do_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, 0, 0);
    do_op("maddu", MD_MADDU, 32'd1,         32'd2, 32'h0000_0002, 32'h0000_0000, 5, 0, 0);
    do_op("div",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0, 0);
    do_op("divu",  MD_DIVU,  32'd7,         32'd2, 32'h0000_0001, 32'h0000_0003, 10, 0, 0);

    // MTHI from idle: immediate write, no busy, LO untouched.
    md.start = 1'b1;
    md.op    = MD_MTHI;
    md.A     = 32'h1234_5678;
    @(negedge clk);
    md.start = 1'b0;
    check("mthi_HI", md.HI, 32'h1234_5678);
    check("mthi_LO", md.LO, 32'h0000_0003);
    check("mthi_busy", W'(md.busy), 32'h0);
    md.hilo_sel = 1'b1;
    #1;
    check("mthi_hilo_out", md.hilo_out, 32'h1234_5678);
    md.hilo_sel = 1'b0;
    @(negedge clk);
    check("mthi_busy_after", W'(md.busy), 32'h0);
    m_hi = 32'h1234_5678;

    do_op("div0",      MD_DIV,  32'd5,   32'd0, 32'h1234_5678, 32'h0000_0003, 10, 0, 0);
    do_op("mult_mtlo", MD_MULT, 32'd6,   32'd7, 32'h0000_0000, 32'h0000_002A, 5, 1, 1);
    do_op("div_reset", MD_DIV,  32'd100, 32'd7, 32'h0000_0000, 32'h0000_0000, 3, 2, 2);

    repeat (12) @(negedge clk);
    check("post_reset_HI", md.HI, 32'h0);
    check("post_reset_LO", md.LO, 32'h0);
    check("post_reset_busy", W'(md.busy), 32'h0);

    do_op("div_ovf",  MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10, 0, 0);
    do_op("mult_b2b", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 5, 0, 0);
    do_op("madd",     MD_MADD, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0, 0);

    md.start = 1'b1;
    md.op    = MD_MTLO;
    md.A     = 32'h0000_CAFE;
    @(negedge clk);
    md.start = 1'b0;
    check("mtlo_LO", md.LO, 32'h0000_CAFE);
    check("mtlo_HI", md.HI, 32'hFFFF_FFFF);
    @(negedge clk);

    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL sb_leftover: %0d expectations never completed, required 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units, required completion");
    $fatal(1);
  end

endmodule
